// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_if.sv
// Alarm unit signal bundle; ALARM_SNOOZE_EN adds the snooze pulse.
interface alarm_if;
  logic       tick_1hz;
  logic       set_en;
  logic       inc_hour;
  logic       inc_min;
  logic       alarm_on;
  logic       stop;
`ifdef ALARM_SNOOZE_EN
  logic       snooze;
`endif
  logic [7:0] Hour;
  logic [7:0] Minute;
  logic [7:0] sethour;
  logic [7:0] setmin;
  logic       ring;

  modport master (
`ifdef ALARM_SNOOZE_EN
    output snooze,
`endif
    output tick_1hz, set_en, inc_hour, inc_min, alarm_on, stop, Hour, Minute,
    input  sethour, setmin, ring
  );

  modport slave (
`ifdef ALARM_SNOOZE_EN
    input  snooze,
`endif
    input  tick_1hz, set_en, inc_hour, inc_min, alarm_on, stop, Hour, Minute,
    output sethour, setmin, ring
  );
endinterface

// File: rtl/bcd_wrap_inc.sv
// Combinational two-digit BCD increment, wrapping to 00 after MAX.
module bcd_wrap_inc #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_comb begin
    if (d == MAX)
      q = 8'h00;
    else if (d[3:0] == 4'd9)
      q = {d[7:4] + 4'd1, 4'd0};
    else
      q = {d[7:4], d[3:0] + 4'd1};
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm time store and ring sequencer. Optional snooze state under ALARM_SNOOZE_EN.
// state  | meaning
// IDLE   | silent, waiting for a rising match edge
// RING   | ring asserted, counting tick_1hz up to RING_SECS
// SNOOZE | silent, counting tick_1hz up to SNOOZE_SECS, then back to RING
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int         RING_SECS = 60,
  parameter logic [7:0] RST_HOUR  = 8'h00,
  parameter logic [7:0] RST_MIN   = 8'h00
`ifdef ALARM_SNOOZE_EN
  ,
  parameter int         SNOOZE_SECS = 300
`endif
) (
  input logic   clk,
  input logic   rst,
  alarm_if.slave bus
);

`ifdef ALARM_SNOOZE_EN
  localparam int MAX_SECS = max_int(RING_SECS, SNOOZE_SECS);
`else
  localparam int MAX_SECS = RING_SECS;
`endif
  localparam int CW = (MAX_SECS > 1) ? $clog2(MAX_SECS) : 1;

  alarm_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] sethour_q, setmin_q, hour_n, min_n;
  logic match, match_q, trigger;

  bcd_wrap_inc #(.MAX(HOUR_MAX)) u_hour_inc (.d(sethour_q), .q(hour_n));
  bcd_wrap_inc #(.MAX(MIN_MAX))  u_min_inc  (.d(setmin_q),  .q(min_n));

  always_ff @(posedge clk) begin
    if (rst) begin
      sethour_q <= RST_HOUR;
      setmin_q  <= RST_MIN;
    end else if (bus.set_en) begin
      if (bus.inc_hour) sethour_q <= hour_n;
      if (bus.inc_min)  setmin_q  <= min_n;
    end
  end

  // Edge detect so a stopped alarm stays quiet for the rest of its minute.
  assign match   = bus.alarm_on && !bus.set_en &&
                   (bus.Hour == sethour_q) && (bus.Minute == setmin_q);
  assign trigger = match && !match_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      match_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      match_q <= match;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_n = RING;
          cnt_n   = '0;
        end
      end
      RING: begin
        if (!bus.alarm_on || bus.stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
`ifdef ALARM_SNOOZE_EN
        else if (bus.snooze) begin
          state_n = SNOOZE;
          cnt_n   = '0;
        end
`endif
        else if (bus.tick_1hz) begin
          if (cnt == CW'(RING_SECS - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!bus.alarm_on || bus.stop) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.tick_1hz) begin
          if (cnt == CW'(SNOOZE_SECS - 1)) begin
            state_n = RING;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    bus.ring    = (state == RING);
    bus.sethour = sethour_q;
    bus.setmin  = setmin_q;
  end

endmodule
